sevseg_scan: RTL

Multiplexed multi-digit seven-segment display driver. It is the parametrised successor to the single-digit decoder and covers full hex 0–F, per-digit decimal points, selectable output polarity and optional leading-zero blanking. It time-division scans `DIGITS` common-anode/cathode digits from one shared segment bus. New values are loaded through a shadow register, and the shadow is committed only at frame boundaries so the display never tears. It sits between the datapath and the board display pins.

---
 rtl/sevseg_scan.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sevseg_scan.sv
// -----------------------------------------------------------------------------
// sevseg_scan
//
// Multiplexed seven-segment display driver. It time-division scans DIGITS
// digits from one shared segment bus and decodes full hex 0-F. It supports
// per-digit decimal points, optional leading-zero blanking and selectable
// output polarity.
//
// New values are loaded into a shadow register. The shadow is copied into the
// displayed register only at the frame wrap, so a frame never mixes old and
// new digits.
//
// Parameters
//   DIGITS         number of scanned digits (1..8)
//   REFRESH_DIV    clock cycles each digit stays lit (>= 2)
//   SEG_ACTIVE_LOW 1: a lit segment / decimal point is driven 0
//   AN_ACTIVE_LOW  1: the selected digit enable is driven 0
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous, active-high reset
//   load      one-cycle strobe capturing value / dp_in
//   value     hex nibbles, value[3:0] is digit 0 (rightmost)
//   dp_in     decimal point request per digit
//   blank_lz  level input enabling leading-zero blanking
//   seg       segment drive, seg[0]=a .. seg[6]=g
//   dp        decimal point drive for the selected digit
//   an        one-hot digit enables
//   frame     one-cycle pulse when digit 0 of a new frame is first shown
// -----------------------------------------------------------------------------
module sevseg_scan #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Inactive output levels, used while in reset.
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

    // Segment pattern for a hex nibble, active-high, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan state. The dwell timer is a down-counter. It reloads at its
    // terminal count, which is the cycle the scan index moves on.
    logic [CNT_W-1:0]    tmr_q, tmr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wrap_q, wrap_d;

    // Displayed and pending (shadow) data
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                pend_v_q, pend_v_d;

    // Registered outputs
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                tc;
    logic                wrap;

    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                blank_sel;
    logic [DIGITS-1:0]   an_sel;
    logic [6:0]          seg_lit;

    // -------------------------------------------------------------------------
    // Scan timer, index and shadow register
    // -------------------------------------------------------------------------
    always_comb begin
        tc   = (tmr_q == '0);
        wrap = tc && (idx_q == IDX_LAST);

        tmr_d = tc ? CNT_LAST : (tmr_q - CNT_W'(1));

        idx_d = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_W'(1));
        end

        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_v_d   = pend_v_q;

        if (wrap) begin
            // A load on the wrap edge bypasses the shadow. It would otherwise
            // miss this commit and wait a whole extra frame.
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
            end else if (pend_v_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_v_d   = 1'b1;
        end

        // Remember the wrap so the output stage can flag the first cycle of
        // the new frame. Reset clears it, so no pulse follows a reset.
        wrap_d = wrap;
    end

    // -------------------------------------------------------------------------
    // Output decode. Works from the registered scan state, so the pins trail
    // the internal index by one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        an_sel    = '0;

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel   = disp_val_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                an_sel[i] = 1'b1;
                // A digit is a leading zero when it and every digit above it
                // are zero. Digit 0 always shows.
                blank_sel = blank_lz && (i != 0) && ((disp_val_q >> (4*i)) == '0);
            end
        end

        seg_lit = blank_sel ? 7'h00 : hex_to_seg(nib_sel);

        seg_d   = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp_d    = SEG_ACTIVE_LOW ? ~dp_sel  : dp_sel;
        an_d    = AN_ACTIVE_LOW  ? ~an_sel  : an_sel;
        frame_d = wrap_q;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q      <= CNT_LAST;
            idx_q      <= '0;
            wrap_q     <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_v_q   <= 1'b0;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            an_q       <= AN_OFF;
            frame_q    <= 1'b0;
        end else begin
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            wrap_q     <= wrap_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_v_q   <= pend_v_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
